// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage. Owns the PC, issues word fetches over a
// req/ready handshake, applies static branch prediction (JAL taken, backward
// conditional branch taken, otherwise fall through) and hands each fetched
// word to decode with its PC, predicted next PC and prediction flag.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] npc_o,
  output logic        predict_result_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_pc_q;
  logic        hold_pred_q;
  logic        valid_q;
  logic [31:0] pc_out_q;
  logic [31:0] inst_q;
  logic [31:0] npc_q;
  logic        pred_q;

  // Static prediction: returns {taken, target} for word w fetched at a.
  function automatic logic [32:0] predict(input logic [31:0] w, input logic [31:0] a);
    logic [31:0] imm;
    logic        taken;
    imm   = 32'd4;
    taken = 1'b0;
    if (w[6:0] == OP_JAL) begin
      imm   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      taken = 1'b1;
    end else if (w[6:0] == OP_BRANCH && w[31]) begin
      imm   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      taken = 1'b1;
    end
    return {taken, a + imm};
  endfunction

  logic [32:0] pred_d;
  logic        pred_taken_d;
  logic [31:0] pred_tgt_d;

  // Prediction on the word currently returning from memory.
  always_comb begin
    pred_d       = predict(mem_data_i, req_addr_q);
    pred_taken_d = pred_d[32];
    pred_tgt_d   = pred_d[31:0];
  end

  // Fetch FSM: PC/request address, one-entry hold buffer and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      hold_inst_q <= 32'd0;
      hold_pc_q   <= 32'd0;
      hold_pred_q <= 1'b0;
      valid_q     <= 1'b0;
      pc_out_q    <= 32'd0;
      inst_q      <= 32'd0;
      npc_q       <= 32'd0;
      pred_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_addr_q <= pc_q;
          state_q    <= FETCH;
        end
        FETCH: begin
          if (jump_i) begin
            pc_q <= jump_addr_i;
            if (mem_ready_i) begin
              req_addr_q <= jump_addr_i;
            end else begin
              // Request already in flight: keep the address stable, drain it.
              state_q <= FLUSH;
            end
          end else if (mem_ready_i) begin
            pc_q <= pred_tgt_d;
            if (!stall_i) begin
              valid_q    <= 1'b1;
              pc_out_q   <= req_addr_q;
              inst_q     <= mem_data_i;
              npc_q      <= pred_tgt_d;
              pred_q     <= pred_taken_d;
              req_addr_q <= pred_tgt_d;
            end else begin
              hold_inst_q <= mem_data_i;
              hold_pc_q   <= req_addr_q;
              hold_pred_q <= pred_taken_d;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (jump_i) begin
            pc_q       <= jump_addr_i;
            req_addr_q <= jump_addr_i;
            state_q    <= FETCH;
          end else if (!stall_i) begin
            // pc_q already holds the buffered word's predicted target.
            valid_q    <= 1'b1;
            pc_out_q   <= hold_pc_q;
            inst_q     <= hold_inst_q;
            npc_q      <= pc_q;
            pred_q     <= hold_pred_q;
            req_addr_q <= pc_q;
            state_q    <= FETCH;
          end
        end
        FLUSH: begin
          if (jump_i) begin
            pc_q <= jump_addr_i;
          end
          if (mem_ready_i) begin
            // Stale word dropped; a same-cycle jump wins over the older target.
            req_addr_q <= jump_i ? jump_addr_i : pc_q;
            state_q    <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o        = (state_q == FETCH) || (state_q == FLUSH);
  assign mem_addr_o       = req_addr_q;
  assign valid_o          = valid_q;
  assign pc_o             = pc_out_q;
  assign inst_o           = inst_q;
  assign npc_o            = npc_q;
  assign predict_result_o = pred_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: reset, first fetch, streaming, JAL/branch
// prediction, stall/hold and redirect handling.
module tb_stage_if;

  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] npc_o;
  logic        predict_result_o;

  int tests = 0;
  int fails = 0;

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .stall_i          (stall_i),
    .jump_i           (jump_i),
    .jump_addr_i      (jump_addr_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ready_i      (mem_ready_i),
    .mem_data_i       (mem_data_i),
    .valid_o          (valid_o),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .npc_o            (npc_o),
    .predict_result_o (predict_result_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_deliver(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] npc, input logic pred);
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, ".pc"},    pc_o, pc);
    chk({tag, ".inst"},  inst_o, inst);
    chk({tag, ".npc"},   npc_o, npc);
    chk({tag, ".pred"},  {31'd0, predict_result_o}, {31'd0, pred});
  endtask

  initial begin
    rst_in = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'd0;
    mem_ready_i = 1'b0; mem_data_i = 32'd0;
    #2;
    chk("rst.req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst.valid", {31'd0, valid_o}, 32'd0);
    chk("rst.pred",  {31'd0, predict_result_o}, 32'd0);
    chk("rst.pc_o",  pc_o, 32'd0);
    chk("rst.inst",  inst_o, 32'd0);
    chk("rst.npc",   npc_o, 32'd0);
    step(); step();
    rst_in = 1'b0;

    // First fetch with 2-cycle memory latency
    step();
    chk("ff.req",  {31'd0, mem_req_o}, 32'd1);
    chk("ff.addr", mem_addr_o, 32'd0);
    step();
    chk("ff.wait_valid", {31'd0, valid_o}, 32'd0);
    chk("ff.wait_addr",  mem_addr_o, 32'd0);
    mem_ready_i = 1'b1; mem_data_i = ADDI;
    step();
    chk_deliver("ff", 32'd0, ADDI, 32'd4, 1'b0);
    chk("ff.next_addr", mem_addr_o, 32'd4);

    // Back-to-back zero-wait fetches
    step(); chk_deliver("b2b4", 32'd4, ADDI, 32'd8, 1'b0);
    step(); chk_deliver("b2b8", 32'd8, ADDI, 32'd12, 1'b0);
    step(); chk_deliver("b2b12", 32'd12, ADDI, 32'd16, 1'b0);
    chk("b2b.addr", mem_addr_o, 32'h10);

    // JAL +16 at 0x10
    mem_data_i = 32'h0100_006F;
    step();
    chk_deliver("jal", 32'h10, 32'h0100_006F, 32'h20, 1'b1);
    chk("jal.next_addr", mem_addr_o, 32'h20);

    // Walk 0x20..0x3C, then backward beq at 0x40
    mem_data_i = ADDI;
    for (int i = 0; i < 8; i++) step();
    chk("walk.pc", pc_o, 32'h3C);
    mem_data_i = 32'hFE00_0EE3;
    step();
    chk_deliver("bwd", 32'h40, 32'hFE00_0EE3, 32'h3C, 1'b1);
    chk("bwd.next_addr", mem_addr_o, 32'h3C);
    mem_data_i = ADDI;
    step();
    chk_deliver("bwd_tgt", 32'h3C, ADDI, 32'h40, 1'b0);
    mem_data_i = 32'h0000_0463;
    step();
    chk_deliver("fwd", 32'h40, 32'h0000_0463, 32'h44, 1'b0);

    // Reset mid-request, then refetch 0 and 4
    mem_ready_i = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("rst2.req",  {31'd0, mem_req_o}, 32'd0);
    chk("rst2.addr", mem_addr_o, 32'd0);
    step();
    rst_in = 1'b0;
    step();
    mem_ready_i = 1'b1; mem_data_i = ADDI;
    step(); chk_deliver("rf0", 32'd0, ADDI, 32'd4, 1'b0);
    step(); chk_deliver("rf4", 32'd4, ADDI, 32'd8, 1'b0);

    // Stall for 3 cycles with ready arriving at pc=8
    stall_i = 1'b1; mem_data_i = 32'h0010_0093;
    step();
    chk("st1.valid", {31'd0, valid_o}, 32'd0);
    chk("st1.req",   {31'd0, mem_req_o}, 32'd0);
    mem_ready_i = 1'b0; mem_data_i = 32'hDEAD_BEEF;
    step();
    chk("st2.valid", {31'd0, valid_o}, 32'd0);
    chk("st2.req",   {31'd0, mem_req_o}, 32'd0);
    step();
    chk("st3.valid", {31'd0, valid_o}, 32'd0);
    chk("st3.req",   {31'd0, mem_req_o}, 32'd0);
    stall_i = 1'b0;
    step();
    chk_deliver("st", 32'd8, 32'h0010_0093, 32'd12, 1'b0);
    chk("st.req",  {31'd0, mem_req_o}, 32'd1);
    chk("st.addr", mem_addr_o, 32'd12);

    // JAL +20 at 12 leads to a request at 0x20
    mem_ready_i = 1'b1; mem_data_i = 32'h0140_006F;
    step();
    chk_deliver("jal20", 32'd12, 32'h0140_006F, 32'h20, 1'b1);
    chk("jal20.addr", mem_addr_o, 32'h20);

    // Redirect to 0x100 while 0x20 is pending
    mem_ready_i = 1'b0; jump_i = 1'b1; jump_addr_i = 32'h100;
    step();
    chk("rd1.valid", {31'd0, valid_o}, 32'd0);
    chk("rd1.req",   {31'd0, mem_req_o}, 32'd1);
    chk("rd1.addr",  mem_addr_o, 32'h20);
    jump_i = 1'b0;
    step();
    chk("rd2.valid", {31'd0, valid_o}, 32'd0);
    chk("rd2.addr",  mem_addr_o, 32'h20);
    mem_ready_i = 1'b1; mem_data_i = ADDI;
    step();
    chk("rd3.valid", {31'd0, valid_o}, 32'd0);
    chk("rd3.req",   {31'd0, mem_req_o}, 32'd1);
    chk("rd3.addr",  mem_addr_o, 32'h100);

    // Redirect coincident with ready
    jump_i = 1'b1; jump_addr_i = 32'h200;
    step();
    chk("rj.valid", {31'd0, valid_o}, 32'd0);
    chk("rj.addr",  mem_addr_o, 32'h200);
    jump_i = 1'b0;
    step();
    chk_deliver("rj", 32'h200, ADDI, 32'h204, 1'b0);
    mem_ready_i = 1'b0;
    step();
    chk("end.valid", {31'd0, valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the RISC-V pipeline. It owns the program counter and issues word-fetch requests to the memory controller over a request/ready handshake. It applies static prediction: JAL is always taken, backward conditional branches are taken, everything else falls through. Each fetched instruction is handed to the decode stage with its PC, predicted next PC and prediction flag, and EX can redirect the stage at any time.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- stall_i  input  1  decode cannot accept an instruction this cycle.
- jump_i  input  1  redirect from EX (mispredict or JALR); highest priority.
- jump_addr_i  input  32  redirect target.
- mem_req_o  output  1  fetch request; held high until mem_ready_i.
- mem_addr_o  output  32  fetch address; stable while mem_req_o is high and ready has not arrived.
- mem_ready_i  input  1  mem_data_i valid for the current request; one-cycle pulse.
- mem_data_i  input  32  fetched instruction word.
- valid_o  output  1  one-cycle pulse; pc_o, inst_o, npc_o and predict_result_o are valid.
- pc_o  output  32  PC of the delivered instruction.
- inst_o  output  32  delivered instruction.
- npc_o  output  32  predicted next PC.
- predict_result_o  output  1  1 = predicted taken.

## Operation
- State register (IDLE, FETCH, HOLD, FLUSH) plus:
  - pc: next address to fetch.
  - req_addr: drives mem_addr_o.
  - hold_inst / hold_pc: one-entry buffer.
- mem_req_o = (state==FETCH || state==FLUSH), decoded from the state register.
- Prediction, computed on the incoming word w at address a:
  - JAL (w[6:0]=1101111): taken; target = a + sext({w[31],w[19:12],w[20],w[30:21],1'b0}).
  - Branch (w[6:0]=1100011) with w[31]=1: taken; target = a + sext({w[31],w[7],w[30:25],w[11:8],1'b0}).
  - Otherwise: not taken; target = a+4.
  - All additions are 32-bit and wrap modulo 2^32.
- State transitions, with jump_i always taking priority:
  - IDLE: next cycle go to FETCH; req_addr <= pc.
  - FETCH, jump_i with or without ready: pc <= req_addr <= jump_addr_i if ready; if not ready, go to FLUSH with pc <= jump_addr_i and req_addr unchanged. Any returning word is discarded.
  - FETCH, ready, !stall_i: deliver the word (valid_o=1 next cycle); pc <= req_addr <= predicted target; stay in FETCH (back-to-back request).
  - FETCH, ready, stall_i: capture the word into the buffer; pc <= predicted target; go to HOLD.
  - HOLD, jump_i: drop the buffer; pc <= req_addr <= jump_addr_i; go to FETCH.
  - HOLD, !stall_i: deliver the buffer; req_addr <= pc; go to FETCH.
  - FLUSH: keep mem_addr_o unchanged. On ready, discard the word, req_addr <= pc, go to FETCH. A jump_i in FLUSH only updates pc.
- valid_o is 0 in every cycle that is not a delivery. A delivery is never issued in the same cycle as jump_i.

## Timing
- Reset (asynchronous, while rst_in=1):
  - state=IDLE; pc=req_addr=RESET_PC.
  - mem_req_o=0, valid_o=0, predict_result_o=0.
  - pc_o=inst_o=npc_o=0.
- After rst_in falls:
  - Edge 1: IDLE→FETCH; mem_req_o=1 with mem_addr_o=RESET_PC.
- Latency: ready sampled at edge N → valid_o high in cycle N+1 (registered outputs).
- Throughput: with zero-wait memory, one instruction per cycle. The memory controller must accept a new address in the cycle after ready.
- Stall:
  - Only one instruction is ever buffered; no fetch is issued while in HOLD.
  - After stall_i falls, delivery happens at the next edge.
- Reset mid-request: the outstanding request is abandoned. The memory controller is reset by the same rst_in.

## Test plan
- **Reset / first fetch:** deassert reset with RESET_PC=0 and a 2-cycle memory latency → mem_addr_o=0; valid_o=1 with pc_o=0, npc_o=4, predict_result_o=0.
- **Back-to-back fetch:** zero-wait memory returning ADDI words → pc_o sequence 0,4,8,12 on consecutive cycles, valid_o continuously high.
- **JAL at 0x10:**
  - Word 0x0100006F (imm=+16) → npc_o=0x20, predict_result_o=1.
  - Next mem_addr_o=0x20.
- **Backward branch at 0x40:**
  - Word 0xFE000EE3 (beq x0,x0,-4) → npc_o=0x3C, predict_result_o=1.
  - Forward beq +8 → npc_o=0x44, predict_result_o=0.
- **Stall:** stall_i high for 3 cycles when ready arrives at pc=8 → no valid_o during the stall. mem_req_o stays 0 in HOLD. One edge after stall_i falls: valid_o with pc_o=8, then a fetch at 12.
- **Redirect:**
  - jump_i to 0x100 while a request at 0x20 is pending (ready 2 cycles later) → mem_addr_o stays 0x20 until ready; that word is discarded, no valid_o; next request at 0x100.
  - jump_i coincident with ready → word discarded; next mem_addr_o=jump_addr_i.
